// File: rtl/cordic_cos_seq.sv
// Iterative rotation-mode CORDIC: one micro-rotation per clock, start/done handshake,
// returns cosine and sine of a clamped signed Q2.20 angle as signed Q2.20 values.
module cordic_cos_seq #(
  parameter int ITER = 20,
  parameter int W    = 22
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic signed [W-1:0] angle,
  output logic                busy,
  output logic                done,
  output logic signed [W-1:0] cos_out,
  output logic signed [W-1:0] sin_out
);

  localparam int IW = W + 2;
  localparam int CW = 5;
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  localparam logic signed [W-1:0] ANG_MAX = {2'b01, {(W-2){1'b0}}};
  localparam logic signed [W-1:0] ANG_MIN = {2'b11, {(W-2){1'b0}}};
  localparam logic signed [W-1:0] OUT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] OUT_MIN = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W:0]   SAT_MAX = {2'b00, {(W-1){1'b1}}};
  localparam logic signed [W:0]   SAT_MIN = {2'b11, {(W-1){1'b0}}};
  // CORDIC gain compensation 0.607252935 scaled by 2^22 (internal Q2.22)
  localparam logic signed [IW-1:0] K_INIT = IW'(32'sd2547003);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t               state_r, state_nxt_s;
  logic signed [IW-1:0] x_r, y_r, z_r;
  logic signed [IW-1:0] x_nxt_s, y_nxt_s, z_nxt_s;
  logic signed [IW-1:0] x_iter_s, y_iter_s, z_iter_s;
  logic signed [IW-1:0] x_sh_s, y_sh_s, atan_s;
  logic signed [W-1:0]  clamp_s;
  logic signed [W:0]    cos_rnd_s, sin_rnd_s;
  logic [CW-1:0]        cnt_r, cnt_nxt_s;
  logic                 busy_r, busy_nxt_s, done_r, done_nxt_s;
  logic signed [W-1:0]  cos_r, sin_r, cos_nxt_s, sin_nxt_s;

  // atan(2^-i) scaled by 2^22; entries beyond ITER-1 are never addressed
  function automatic logic signed [IW-1:0] atan_rom(input logic [CW-1:0] idx);
    logic signed [IW-1:0] val;
    case (idx)
      5'd0:    val = IW'(32'sd3294199);
      5'd1:    val = IW'(32'sd1944679);
      5'd2:    val = IW'(32'sd1027515);
      5'd3:    val = IW'(32'sd521583);
      5'd4:    val = IW'(32'sd261803);
      5'd5:    val = IW'(32'sd131029);
      5'd6:    val = IW'(32'sd65531);
      5'd7:    val = IW'(32'sd32767);
      5'd8:    val = IW'(32'sd16384);
      5'd9:    val = IW'(32'sd8192);
      5'd10:   val = IW'(32'sd4096);
      5'd11:   val = IW'(32'sd2048);
      5'd12:   val = IW'(32'sd1024);
      5'd13:   val = IW'(32'sd512);
      5'd14:   val = IW'(32'sd256);
      5'd15:   val = IW'(32'sd128);
      5'd16:   val = IW'(32'sd64);
      5'd17:   val = IW'(32'sd32);
      5'd18:   val = IW'(32'sd16);
      5'd19:   val = IW'(32'sd8);
      5'd20:   val = IW'(32'sd4);
      5'd21:   val = IW'(32'sd2);
      default: val = {IW{1'b0}};
    endcase
    return val;
  endfunction

  function automatic logic signed [W-1:0] sat_out(input logic signed [W:0] v);
    logic signed [W-1:0] r;
    if (v > SAT_MAX) begin
      r = OUT_MAX;
    end else if (v < SAT_MIN) begin
      r = OUT_MIN;
    end else begin
      r = v[W-1:0];
    end
    return r;
  endfunction

  // input clamp to [-1.0, +1.0] keeps the angle inside the convergence range
  always_comb begin
    if (angle > ANG_MAX) begin
      clamp_s = ANG_MAX;
    end else if (angle < ANG_MIN) begin
      clamp_s = ANG_MIN;
    end else begin
      clamp_s = angle;
    end
  end

  // one micro-rotation plus round-half-up of the two LSB guard bits
  always_comb begin
    x_sh_s = x_r >>> cnt_r;
    y_sh_s = y_r >>> cnt_r;
    atan_s = atan_rom(cnt_r);
    if (z_r[IW-1]) begin
      x_iter_s = x_r + y_sh_s;
      y_iter_s = y_r - x_sh_s;
      z_iter_s = z_r + atan_s;
    end else begin
      x_iter_s = x_r - y_sh_s;
      y_iter_s = y_r + x_sh_s;
      z_iter_s = z_r - atan_s;
    end
    // (v + 2) >>> 2 equals floor(v/4) plus bit 1 of v
    cos_rnd_s = {x_iter_s[IW-1], x_iter_s[IW-1:2]} + {{W{1'b0}}, x_iter_s[1]};
    sin_rnd_s = {y_iter_s[IW-1], y_iter_s[IW-1:2]} + {{W{1'b0}}, y_iter_s[1]};
  end

  // next-state and next-output logic
  always_comb begin
    state_nxt_s = state_r;
    x_nxt_s     = x_r;
    y_nxt_s     = y_r;
    z_nxt_s     = z_r;
    cnt_nxt_s   = cnt_r;
    busy_nxt_s  = busy_r;
    done_nxt_s  = 1'b0;
    cos_nxt_s   = cos_r;
    sin_nxt_s   = sin_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          x_nxt_s     = K_INIT;
          y_nxt_s     = {IW{1'b0}};
          z_nxt_s     = {clamp_s, 2'b00};
          cnt_nxt_s   = {CW{1'b0}};
          busy_nxt_s  = 1'b1;
          state_nxt_s = RUN;
        end else begin
          busy_nxt_s  = 1'b0;
        end
      end
      RUN: begin
        x_nxt_s   = x_iter_s;
        y_nxt_s   = y_iter_s;
        z_nxt_s   = z_iter_s;
        cnt_nxt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        if (cnt_r == LAST) begin
          cos_nxt_s   = sat_out(cos_rnd_s);
          sin_nxt_s   = sat_out(sin_rnd_s);
          done_nxt_s  = 1'b1;
          busy_nxt_s  = 1'b0;
          cnt_nxt_s   = {CW{1'b0}};
          state_nxt_s = IDLE;
        end else begin
          busy_nxt_s  = 1'b1;
        end
      end
      default: begin
        busy_nxt_s  = 1'b0;
        cnt_nxt_s   = {CW{1'b0}};
        state_nxt_s = IDLE;
      end
    endcase
  end

  // state, datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      x_r     <= {IW{1'b0}};
      y_r     <= {IW{1'b0}};
      z_r     <= {IW{1'b0}};
      cnt_r   <= {CW{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      cos_r   <= {W{1'b0}};
      sin_r   <= {W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      x_r     <= x_nxt_s;
      y_r     <= y_nxt_s;
      z_r     <= z_nxt_s;
      cnt_r   <= cnt_nxt_s;
      busy_r  <= busy_nxt_s;
      done_r  <= done_nxt_s;
      cos_r   <= cos_nxt_s;
      sin_r   <= sin_nxt_s;
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign cos_out = cos_r;
  assign sin_out = sin_r;

endmodule

// File: tb/tb_cordic_cos_seq.sv
// Self-checking bench for cordic_cos_seq: random and directed angles checked
// against real-valued cos/sin of the clamped angle, plus handshake and reset timing.
module tb_cordic_cos_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [21:0] angle;
  logic        busy;
  logic        done;
  logic [21:0] cos_out;
  logic [21:0] sin_out;

  int cmp_cnt  = 0;
  int fail_cnt = 0;

  cordic_cos_seq #(.ITER(20), .W(22)) dut (
    .clk(clk), .reset(reset), .start(start), .angle(angle),
    .busy(busy), .done(done), .cos_out(cos_out), .sin_out(sin_out)
  );

  always #5 clk = ~clk;

  // reference: clamp to [-1, 1] rad, then real cos/sin scaled by 2^20 and rounded
  function automatic int ref_trig(input logic [21:0] raw, input bit want_sin);
    int  r;
    real a;
    r = int'($signed(raw));
    if (r > 1048576) r = 1048576;
    else if (r < -1048576) r = -1048576;
    a = real'(r) / 1048576.0;
    if (want_sin) return int'($sin(a) * 1048576.0);
    else return int'($cos(a) * 1048576.0);
  endfunction

  task automatic launch_now(input logic [21:0] a);
    angle = a;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    angle = 22'($urandom);
  endtask

  task automatic launch(input logic [21:0] a);
    @(negedge clk);
    launch_now(a);
  endtask

  // entered at the negedge following the accepting edge
  task automatic wait_done(output int lat, output int busy_cycles, output bit got);
    lat = 0;
    got = 1'b0;
    busy_cycles = (busy === 1'b1) ? 1 : 0;
    while (!got && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (done === 1'b1) got = 1'b1;
      else if (busy === 1'b1) busy_cycles++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    angle = 22'h000000;
    repeat (3) @(negedge clk);
    cmp_cnt += 4;
    if (busy !== 1'b0) begin fail_cnt++; $display("FAIL reset_busy got %b want 0", busy); end
    if (done !== 1'b0) begin fail_cnt++; $display("FAIL reset_done got %b want 0", done); end
    if (cos_out !== 22'h000000) begin fail_cnt++; $display("FAIL reset_cos got %h want 000000", cos_out); end
    if (sin_out !== 22'h000000) begin fail_cnt++; $display("FAIL reset_sin got %h want 000000", sin_out); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    cmp_cnt++;
    if (busy !== 1'b0) begin fail_cnt++; $display("FAIL idle_busy got %b want 0", busy); end
  endtask

  task automatic test_zero;
    int lat, bc, c, s, c_hold;
    bit got;
    launch(22'h000000);
    wait_done(lat, bc, got);
    c = int'($signed(cos_out));
    s = int'($signed(sin_out));
    cmp_cnt += 6;
    if (!got || lat !== 20) begin fail_cnt++; $display("FAIL zero_latency got %0d (done=%b) want 20", lat, got); end
    if (bc !== 20) begin fail_cnt++; $display("FAIL zero_busy_cycles got %0d want 20", bc); end
    if (busy !== 1'b0) begin fail_cnt++; $display("FAIL zero_busy_at_done got %b want 0", busy); end
    if (c - 1048576 > 8 || c - 1048576 < -8) begin fail_cnt++; $display("FAIL zero_cos got %0d want 1048576+-8", c); end
    if (s > 8 || s < -8) begin fail_cnt++; $display("FAIL zero_sin got %0d want 0+-8", s); end
    @(negedge clk);
    if (done !== 1'b0) begin fail_cnt++; $display("FAIL zero_done_pulse got %b want 0", done); end
    c_hold = c;
    repeat (5) @(negedge clk);
    c = int'($signed(cos_out));
    cmp_cnt++;
    if (c !== c_hold) begin fail_cnt++; $display("FAIL zero_hold got %0d want %0d", c, c_hold); end
  endtask

  task automatic test_angles;
    logic [21:0] tab [5];
    int lat, bc, c, s, ec, es;
    bit got;
    tab[0] = 22'h100000;
    tab[1] = 22'h380000;
    tab[2] = 22'h1FFFFF;
    tab[3] = 22'h200000;
    tab[4] = 22'h0C0000;
    for (int k = 0; k < 5; k++) begin
      launch(tab[k]);
      wait_done(lat, bc, got);
      c  = int'($signed(cos_out));
      s  = int'($signed(sin_out));
      ec = ref_trig(tab[k], 1'b0);
      es = ref_trig(tab[k], 1'b1);
      cmp_cnt += 3;
      if (!got || lat !== 20) begin fail_cnt++; $display("FAIL angle_latency a=%h got %0d want 20", tab[k], lat); end
      if (c - ec > 8 || c - ec < -8) begin fail_cnt++; $display("FAIL angle_cos a=%h got %0d want %0d+-8", tab[k], c, ec); end
      if (s - es > 8 || s - es < -8) begin fail_cnt++; $display("FAIL angle_sin a=%h got %0d want %0d+-8", tab[k], s, es); end
    end
  endtask

  task automatic test_random;
    logic [21:0] a;
    int lat, bc, c, s, ec, es;
    bit got;
    for (int k = 0; k < 24; k++) begin
      if (k % 3 == 0) a = 22'($urandom);
      else a = 22'($urandom_range(2097152, 0) - 1048576);
      launch(a);
      wait_done(lat, bc, got);
      c  = int'($signed(cos_out));
      s  = int'($signed(sin_out));
      ec = ref_trig(a, 1'b0);
      es = ref_trig(a, 1'b1);
      cmp_cnt += 3;
      if (!got || lat !== 20) begin fail_cnt++; $display("FAIL rand_latency a=%h got %0d want 20", a, lat); end
      if (c - ec > 8 || c - ec < -8) begin fail_cnt++; $display("FAIL rand_cos a=%h got %0d want %0d+-8", a, c, ec); end
      if (s - es > 8 || s - es < -8) begin fail_cnt++; $display("FAIL rand_sin a=%h got %0d want %0d+-8", a, s, es); end
    end
  endtask

  task automatic test_back_to_back;
    int lat, bc, c, s, ec, es;
    bit got;
    launch(22'h040000);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (done === 1'b1) got = 1'b1;
      else if (lat == 5) begin angle = 22'h300000; start = 1'b1; end
      else begin start = 1'b0; angle = 22'h000000; end
    end
    start = 1'b0;
    c  = int'($signed(cos_out));
    ec = ref_trig(22'h040000, 1'b0);
    cmp_cnt += 2;
    if (!got || lat !== 20) begin fail_cnt++; $display("FAIL ignore_latency got %0d want 20", lat); end
    if (c - ec > 8 || c - ec < -8) begin fail_cnt++; $display("FAIL ignore_cos got %0d want %0d+-8", c, ec); end
    launch_now(22'h300000);
    wait_done(lat, bc, got);
    c  = int'($signed(cos_out));
    s  = int'($signed(sin_out));
    ec = ref_trig(22'h300000, 1'b0);
    es = ref_trig(22'h300000, 1'b1);
    cmp_cnt += 3;
    if (!got || lat !== 20) begin fail_cnt++; $display("FAIL b2b_latency got %0d want 20", lat); end
    if (c - ec > 8 || c - ec < -8) begin fail_cnt++; $display("FAIL b2b_cos got %0d want %0d+-8", c, ec); end
    if (s - es > 8 || s - es < -8) begin fail_cnt++; $display("FAIL b2b_sin got %0d want %0d+-8", s, es); end
  endtask

  task automatic test_reset_mid_run;
    int lat, bc, c, s, ec, es, spurious;
    bit got;
    launch(22'h0A0000);
    repeat (10) begin @(posedge clk); @(negedge clk); end
    #1 reset = 1'b1;
    #1;
    cmp_cnt += 4;
    if (busy !== 1'b0) begin fail_cnt++; $display("FAIL abort_busy got %b want 0", busy); end
    if (done !== 1'b0) begin fail_cnt++; $display("FAIL abort_done got %b want 0", done); end
    if (cos_out !== 22'h000000) begin fail_cnt++; $display("FAIL abort_cos got %h want 000000", cos_out); end
    if (sin_out !== 22'h000000) begin fail_cnt++; $display("FAIL abort_sin got %h want 000000", sin_out); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    spurious = 0;
    repeat (30) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) spurious++;
    end
    cmp_cnt++;
    if (spurious !== 0) begin fail_cnt++; $display("FAIL abort_no_done got %0d active cycles want 0", spurious); end
    launch(22'h3B0000);
    wait_done(lat, bc, got);
    c  = int'($signed(cos_out));
    s  = int'($signed(sin_out));
    ec = ref_trig(22'h3B0000, 1'b0);
    es = ref_trig(22'h3B0000, 1'b1);
    cmp_cnt += 3;
    if (!got || lat !== 20) begin fail_cnt++; $display("FAIL after_reset_latency got %0d want 20", lat); end
    if (c - ec > 8 || c - ec < -8) begin fail_cnt++; $display("FAIL after_reset_cos got %0d want %0d+-8", c, ec); end
    if (s - es > 8 || s - es < -8) begin fail_cnt++; $display("FAIL after_reset_sin got %0d want %0d+-8", s, es); end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_angles();
    test_random();
    test_back_to_back();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
